// File: rtl/bpred_pkg.sv
// Shared types for the branch-prediction resolve queue: default widths,
// the in-flight entry payload and the recovery FSM states.
package bpred_pkg;

  localparam int unsigned BP_PC_W  = 8;
  localparam int unsigned BP_GHR_W = 4;

  typedef struct packed {
    logic [BP_PC_W-1:0]  pc;
    logic                taken;
    logic [BP_GHR_W-1:0] ghr;
  } bpred_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bpred_state_e;

endpackage

// File: rtl/bpred_fifo.sv
// Circular in-flight store for predictions. A flush pops the head and
// discards every younger entry in the same edge.
module bpred_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Head is consumed; everything behind it is wrong-path.
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wr_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bpred_resolve_queue.sv
// In-order resolve stage: matches queued predictions against outcomes,
// drives the BHT update, flushes on a miss with a repaired GHR, keeps stats.
module bpred_resolve_queue
  import bpred_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = BP_PC_W,
  parameter int unsigned GHR_W = BP_GHR_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic [GHR_W-1:0] pred_ghr,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic [GHR_W-1:0] upd_index,
  output logic             upd_taken,
  output logic [PC_W-1:0]  upd_pc,
  output logic             mispredict,
  output logic [GHR_W-1:0] restore_ghr,
  output logic             res_err,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned ENT_W  = PC_W + 1 + GHR_W;
  localparam int unsigned QCNT_W = $clog2(DEPTH) + 1;

  bpred_state_e     state_q, state_d;
  logic             upd_valid_q, upd_valid_d;
  logic [GHR_W-1:0] upd_index_q, upd_index_d;
  logic             upd_taken_q, upd_taken_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic             mispredict_q, mispredict_d;
  logic [GHR_W-1:0] restore_ghr_q, restore_ghr_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [ENT_W-1:0]  head;
  logic [QCNT_W-1:0] count;
  logic [PC_W-1:0]   head_pc;
  logic              head_taken;
  logic [GHR_W-1:0]  head_ghr;
  logic              res_fire, miss, push;

  assign head_pc    = head[ENT_W-1 -: PC_W];
  assign head_taken = head[GHR_W];
  assign head_ghr   = head[GHR_W-1:0];

  // Ready depends on registered state only; a resolve cannot free a slot same-cycle.
  assign pred_ready = (state_q == RUN) && (count < QCNT_W'(DEPTH));
  assign res_fire   = res_valid && (state_q == RUN) && (count != '0);
  assign miss       = res_fire && (head_taken != res_taken);
  assign push       = pred_valid && pred_ready && !miss;

  bpred_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (res_fire),
    .flush_i (miss),
    .wdata_i ({pred_pc, pred_taken, pred_ghr}),
    .rdata_o (head),
    .count_o (count)
  );

  always_comb begin
    state_d       = state_q;
    upd_valid_d   = 1'b0;
    mispredict_d  = 1'b0;
    upd_index_d   = upd_index_q;
    upd_taken_d   = upd_taken_q;
    upd_pc_d      = upd_pc_q;
    restore_ghr_d = restore_ghr_q;
    res_err_d     = res_err_q;
    total_cnt_d   = total_cnt_q;
    miss_cnt_d    = miss_cnt_q;

    case (state_q)
      RUN:     if (miss) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase

    if (res_fire) begin
      upd_valid_d = 1'b1;
      upd_index_d = head_ghr;
      upd_taken_d = res_taken;
      upd_pc_d    = head_pc;
      if (total_cnt_q != '1) total_cnt_d = total_cnt_q + CNT_W'(1);
    end else if (res_valid) begin
      res_err_d = 1'b1;
    end

    if (miss) begin
      mispredict_d  = 1'b1;
      restore_ghr_d = {head_ghr[GHR_W-2:0], res_taken};
      if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
      upd_pc_q      <= '0;
      mispredict_q  <= 1'b0;
      restore_ghr_q <= '0;
      res_err_q     <= 1'b0;
      total_cnt_q   <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      upd_valid_q   <= upd_valid_d;
      upd_index_q   <= upd_index_d;
      upd_taken_q   <= upd_taken_d;
      upd_pc_q      <= upd_pc_d;
      mispredict_q  <= mispredict_d;
      restore_ghr_q <= restore_ghr_d;
      res_err_q     <= res_err_d;
      total_cnt_q   <= total_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_index   = upd_index_q;
  assign upd_taken   = upd_taken_q;
  assign upd_pc      = upd_pc_q;
  assign mispredict  = mispredict_q;
  assign restore_ghr = restore_ghr_q;
  assign res_err     = res_err_q;
  assign total_cnt   = total_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: doc/bpred_resolve_queue.md
# bpred_resolve_queue

In-order resolution stage downstream of the global branch predictor. Holds each in-flight prediction with its PC and the GHR snapshot used to index the BHT, and matches it against the actual outcome when the branch resolves. Drives the predictor's update path, raises a misprediction flush with a repaired GHR, and keeps accuracy counters.

## Interface
- `DEPTH`, 4: in-flight entries; power of two, 2..16.
- `PC_W`, 8: branch PC width.
- `GHR_W`, 4: GHR / BHT index width.
- `CNT_W`, 16: statistics counter width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pred_valid` in 1: new prediction offered.
- `pred_ready` out 1: queue accepts the offered prediction this cycle.
- `pred_pc` in PC_W: branch PC.
- `pred_taken` in 1: predicted direction.
- `pred_ghr` in GHR_W: GHR value used to form the index.
- `res_valid` in 1: oldest branch resolved this cycle.
- `res_taken` in 1: actual direction.
- `upd_valid` out 1: one-cycle pulse, BHT update request.
- `upd_index` out GHR_W: index to update, equal to the stored `pred_ghr`.
- `upd_taken` out 1: actual outcome for the counter update.
- `upd_pc` out PC_W: PC of the resolved branch.
- `mispredict` out 1: one-cycle pulse that accompanies `upd_valid` when the prediction was wrong.
- `restore_ghr` out GHR_W: repaired GHR, `{stored_ghr[GHR_W-2:0], res_taken}`. Valid only while `mispredict` is high.
- `res_err` out 1: sticky flag, set when `res_valid` arrives on an empty queue.
- `total_cnt` out CNT_W: resolved branches, saturating.
- `miss_cnt` out CNT_W: mispredictions, saturating.

## Operation
- Circular FIFO with `wr_ptr`, `rd_ptr` and `count` (width log2(DEPTH)+1). Each entry holds {pc, taken, ghr}.
- Push occurs when `pred_valid && pred_ready`. `pred_ready = (state==RUN) && (count<DEPTH)`. It does not depend on `res_valid`, so a full queue rejects a push even if a resolve occurs in the same cycle.
- Resolve occurs when `res_valid && count!=0`:
  - pop the head entry;
  - register the update outputs from that entry;
  - miss = head.taken != res_taken.
- Miss handling:
  - clear the whole queue: `count←0`, `wr_ptr←rd_ptr+1`; all younger entries are wrong-path;
  - any push in the same cycle is discarded;
  - state → RECOVER.
- FSM:
  - RUN: pushes and resolves allowed.
  - RECOVER: lasts exactly one cycle with `pred_ready=0`. The upstream predictor loads `restore_ghr` during this bubble. Any `res_valid` in RECOVER is treated as resolve-on-empty (`res_err` set). Then → RUN.
- Resolve on an empty queue: no pop, no `upd_valid`, `res_err←1`. Cleared only by reset.
- Non-miss push and resolve in the same cycle: both take effect, count unchanged.
- Counters: `total_cnt` increments on every valid resolve; `miss_cnt` increments on misses. Both hold at all-ones.
- Pointer wrap is modulo DEPTH and is natural given the power-of-two depth.

## Timing
- Reset values (apply on the clock edge with `reset` high, including mid-operation):
  - `state=RUN`, pointers and count 0;
  - `upd_valid`, `mispredict`, `res_err` = 0;
  - `upd_index`, `upd_taken`, `upd_pc`, `restore_ghr` = 0;
  - `total_cnt = miss_cnt = 0`;
  - `pred_ready` = 1 in the first cycle after reset deasserts.
- Resolve latency is 1 cycle: when `res_valid` is sampled at edge N, `upd_*`, `mispredict` and `restore_ghr` are valid during cycle N+1, as a single-cycle pulse.
- Counters reflect a resolve in cycle N+1, the same cycle as `upd_valid`.
- Miss at edge N:
  - `pred_ready` is low for cycle N+1 only;
  - the first new push is accepted at edge N+2.
- `pred_ready` is a registered-state function of `state`/`count` and has no combinational path from `pred_valid` or `res_valid`.

## Structure
- Shared package `bpred_pkg`:
  - `PC_W`, `GHR_W` defaults;
  - entry struct `bpred_entry_t` {pc, taken, ghr};
  - state enum {RUN, RECOVER}.
- Sub-module `bpred_fifo`: storage and pointers, with push, pop and flush inputs. The top level holds the FSM, compare logic, output registers and counters.

## Test plan
- Reset then 3 pushes {pc 0x10/T/ghr 0x3, 0x14/N/0x6, 0x18/T/0xC}, then 3 resolves T,N,T → three `upd_valid` pulses with indices 0x3, 0x6, 0xC; `mispredict` stays 0; `total_cnt=3`, `miss_cnt=0`.
- Fill DEPTH=4 entries, then hold `pred_valid` → `pred_ready=0`, 5th entry not stored. Resolve one correctly while pushing → that push is still rejected that cycle and accepted on the next.
- 3 entries queued, head pred T ghr 0x5, resolve N with a push in the same cycle → `mispredict=1`, `restore_ghr=0xA`, push dropped, `pred_ready=0` for one cycle, count 0, `miss_cnt=1`.
- `res_valid` on an empty queue → no `upd_valid`; `res_err=1` and stays 1 through later traffic until reset.
- Reset asserted with 2 entries queued and a resolve pending → next cycle all outputs are at reset values, the queue is empty, and the next resolve sets `res_err`.
- With `CNT_W` overridden to 4, run 20 mispredicting resolves → `total_cnt` and `miss_cnt` saturate at 0xF.
